fifo_mst_arb: RTL and testbench
===============================

# fifo_mst_arb

Channel arbiter for the FT600 master FIFO path, directly upstream of the master bus FSM. Collects per-channel master-write requests (channel has data for the FT600) and master-read requests (channel has space for FT600 data), and selects one request per bus transaction by round-robin. It issues a single-cycle `grant` with a stable direction, channel index and endpoint read pointer, then holds the selection until the FSM returns to idle. It also routes the FSM's read-pointer commit back to the granted channel.

## Interface
Parameters:
- `NUM_CH`, 4, number of endpoint channels (1..8)
- `EPm_MSZ`, 11, MSB of endpoint pointer (pointer width `EPm_MSZ+1`)
- `START_TMO`, 4, cycles allowed for FSM to leave idle after `grant`

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `wr_req`  in  NUM_CH  channel n has data to send (master write)
- `rd_req`  in  NUM_CH  channel n has space to receive (master read)
- `ep_rd_ptr_in`  in  NUM_CH*(EPm_MSZ+1)  packed per-channel read pointers, channel 0 in LSBs
- `idle_st`  in  1  FSM in idle state
- `u_rd_ptr`  in  1  FSM pointer-commit strobe
- `c_rd_ptr`  in  EPm_MSZ+1  FSM current read pointer
- `grant`  out  1  one-cycle transaction start to FSM
- `m_rd_wr`  out  1  1: master read, 0: master write
- `ch_sel`  out  3  granted channel index
- `ep_rd_ptr`  out  EPm_MSZ+1  read pointer of granted channel
- `rd_ptr_upd`  out  NUM_CH  one-hot pointer commit to channel `ch_sel`
- `rd_ptr_val`  out  EPm_MSZ+1  pointer value accompanying `rd_ptr_upd`
- `busy`  out  1  transaction in progress (not in ARB_IDLE)
- `arb_err`  out  1  sticky: FSM failed to start within `START_TMO`

## Operation
- Request slots: 2*NUM_CH, ordered wr0, rd0, wr1, rd1, ... Slot k active when the corresponding `wr_req`/`rd_req` bit is high.
- Round-robin pointer `rr` (slot index, reset 0): winner is the first active slot at or after `rr`, wrapping modulo 2*NUM_CH.
- States:
  - ARB_IDLE: if `idle_st` high and any slot active, latch winner into `ch_sel`/`m_rd_wr`, register `ep_rd_ptr` from `ep_rd_ptr_in[ch_sel]`, go ARB_GRANT. Otherwise stay.
  - ARB_GRANT: `grant`=1 for exactly this cycle; go ARB_START, timeout counter cleared.
  - ARB_START: `idle_st` low -> ARB_BUSY. Counter reaches `START_TMO` with `idle_st` still high -> set `arb_err`, go ARB_IDLE, `rr` unchanged.
  - ARB_BUSY: `idle_st` high -> ARB_DONE.
  - ARB_DONE: `rr` <= granted slot + 1 (mod 2*NUM_CH); go ARB_IDLE.
- `ch_sel`, `m_rd_wr`, `ep_rd_ptr` are held constant from ARB_GRANT through ARB_DONE; requests are sampled only in ARB_IDLE, and later deassertion is ignored.
- Pointer commit: in ARB_START/ARB_BUSY/ARB_DONE, with `m_rd_wr`=0 and `u_rd_ptr`=1, the next cycle has `rd_ptr_upd` = one-hot(`ch_sel`) and `rd_ptr_val` = `c_rd_ptr`. `u_rd_ptr` in any other state, or with `m_rd_wr`=1, is ignored. Multi-cycle `u_rd_ptr` yields one `rd_ptr_upd` per cycle.
- `arb_err` clears only on reset.

## Timing
- Reset values: `grant`=0, `m_rd_wr`=0, `ch_sel`=0, `ep_rd_ptr`=0, `rd_ptr_upd`=0, `rd_ptr_val`=0, `busy`=0, `arb_err`=0, `rr`=0, state ARB_IDLE.
- Request latency: request sampled in ARB_IDLE at edge N; `grant` high in cycle N+1; `ep_rd_ptr` valid from N+1 (same cycle as `grant`, as needed for the FSM pointer load).
- Minimum spacing between grants: 4 cycles plus FSM transaction length; the FSM idle cycle is always observed in ARB_DONE before re-arbitration.
- Reset assertion mid-transaction returns all outputs to reset values immediately (asynchronously); no `rd_ptr_upd` is emitted.

## Configuration
- `FIFO_MST_ARB_WR_PRIO_EN` defined: any active write slot beats all read slots. Round-robin applies among write slots and, when no write is active, among read slots.
- Not defined: pure round-robin across all 2*NUM_CH slots as above.

## Test plan
- Single request: `wr_req`=4'b0100, `ep_rd_ptr_in[2]`=12'h123 -> `grant` pulse, `ch_sel`=2, `m_rd_wr`=0, `ep_rd_ptr`=12'h123 in the grant cycle.
- Fairness: all `wr_req` and `rd_req` held high, FSM model returns idle 6 cycles after leaving it -> grant order wr0, rd0, wr1, rd1, …, rd3, wr0.
- Pointer commit: granted write on ch1, FSM pulses `u_rd_ptr` with `c_rd_ptr`=12'h040 -> `rd_ptr_upd`=4'b0010, `rd_ptr_val`=12'h040 one cycle later. The same stimulus on a read grant gives `rd_ptr_upd`=0.
- Start timeout: `idle_st` held high after `grant` -> `arb_err`=1 after 4 cycles, back to ARB_IDLE, same slot re-granted.
- Reset mid-ARB_BUSY: `rstn` low -> `grant`/`busy`/`rd_ptr_upd` are 0 and `rr`=0. The first grant after release goes to the lowest active slot.
- Macro on: `rd_req`=4'b0001 and `wr_req`=4'b1000 with `rr` at rd0 -> wr3 granted first.

Source files
------------

// File: rtl/fifo_mst_arb.sv
// fifo_mst_arb: round-robin channel arbiter in front of the FT600 master bus FSM.
// It collects per-channel write requests (the channel has data) and read requests
// (the channel has space), then grants one slot per bus transaction. The selection
// is held until the FSM returns to idle. The arbiter also routes the FSM's
// read-pointer commit back to the granted channel.
//
// Optional feature: define FIFO_MST_ARB_WR_PRIO_EN so that write slots always beat
// read slots. Round-robin then applies within each class.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   wr_req, rd_req per-channel master-write / master-read requests
//   ep_rd_ptr_in   packed per-channel read pointers, channel 0 in the LSBs
//   idle_st        FSM is in its idle state
//   u_rd_ptr       FSM pointer-commit strobe; c_rd_ptr is the pointer value
//   grant          one-cycle transaction start
//   m_rd_wr        1 = master read, 0 = master write
//   ch_sel         granted channel index
//   ep_rd_ptr      read pointer of the granted channel
//   rd_ptr_upd     one-hot pointer commit; rd_ptr_val is the committed value
//   busy           transaction in progress
//   arb_err        sticky flag: the FSM did not leave idle in time
module fifo_mst_arb #(
  parameter int NUM_CH    = 4,
  parameter int EPm_MSZ   = 11,
  parameter int START_TMO = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_CH-1:0]           wr_req,
  input  logic [NUM_CH-1:0]           rd_req,
  input  logic [NUM_CH*(EPm_MSZ+1)-1:0] ep_rd_ptr_in,
  input  logic                        idle_st,
  input  logic                        u_rd_ptr,
  input  logic [EPm_MSZ:0]            c_rd_ptr,
  output logic                        grant,
  output logic                        m_rd_wr,
  output logic [2:0]                  ch_sel,
  output logic [EPm_MSZ:0]            ep_rd_ptr,
  output logic [NUM_CH-1:0]           rd_ptr_upd,
  output logic [EPm_MSZ:0]            rd_ptr_val,
  output logic                        busy,
  output logic                        arb_err
);

  localparam int NS = 2 * NUM_CH;
  localparam int SW = $clog2(NS);
  localparam int PW = EPm_MSZ + 1;
  localparam int TW = $clog2(START_TMO + 1);

  typedef enum logic [2:0] {ARB_IDLE, ARB_GRANT, ARB_START, ARB_BUSY, ARB_DONE} state_t;

  state_t          state;
  logic [SW-1:0]   rr;
  logic [SW-1:0]   slot;
  logic [TW-1:0]   cnt;

  logic [NS-1:0]   req;
  logic [NS-1:0]   wmask;
  logic [NS-1:0]   cand;
  logic            found;
  logic [SW-1:0]   win;
  logic [SW-1:0]   win_ch;
  logic [PW-1:0]   win_ptr;
  int unsigned     idx;

  // Slots are interleaved wr0, rd0, wr1, rd1, ... so even slots are writes.
  always_comb begin
    req   = '0;
    wmask = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      req[2*n]     = wr_req[n];
      req[2*n+1]   = rd_req[n];
      wmask[2*n]   = 1'b1;
    end
`ifdef FIFO_MST_ARB_WR_PRIO_EN
    // Masking down to the write slots keeps a single rotating search for both modes.
    cand = (|(req & wmask)) ? (req & wmask) : req;
`else
    cand = req;
`endif
  end

  // The winner is the first candidate at or after rr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NS; i++) begin
      idx = (32'(rr) + i) % NS;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end

  always_comb begin
    win_ch  = win >> 1;
    win_ptr = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (32'(win_ch) == n) win_ptr = ep_rd_ptr_in[n*PW +: PW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ARB_IDLE;
      rr         <= '0;
      slot       <= '0;
      cnt        <= '0;
      grant      <= 1'b0;
      m_rd_wr    <= 1'b0;
      ch_sel     <= '0;
      ep_rd_ptr  <= '0;
      rd_ptr_upd <= '0;
      rd_ptr_val <= '0;
      busy       <= 1'b0;
      arb_err    <= 1'b0;
    end else begin
      rd_ptr_upd <= '0;
      if ((state == ARB_START || state == ARB_BUSY || state == ARB_DONE) &&
          !m_rd_wr && u_rd_ptr) begin
        rd_ptr_upd <= NUM_CH'(1) << ch_sel;
        rd_ptr_val <= c_rd_ptr;
      end

      case (state)
        ARB_IDLE: begin
          if (idle_st && found) begin
            slot      <= win;
            ch_sel    <= 3'(win_ch);
            m_rd_wr   <= win[0];
            ep_rd_ptr <= win_ptr;
            grant     <= 1'b1;
            busy      <= 1'b1;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          grant <= 1'b0;
          cnt   <= '0;
          state <= ARB_START;
        end
        ARB_START: begin
          if (!idle_st) begin
            state <= ARB_BUSY;
          end else if (cnt == TW'(START_TMO - 1)) begin
            // A failed start leaves rr untouched, so the same slot wins again.
            arb_err <= 1'b1;
            busy    <= 1'b0;
            state   <= ARB_IDLE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        ARB_BUSY: begin
          if (idle_st) state <= ARB_DONE;
        end
        ARB_DONE: begin
          rr    <= (slot == SW'(NS - 1)) ? '0 : slot + SW'(1);
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_mst_arb.sv
// Directed testbench for fifo_mst_arb with default parameters (4 channels,
// 12-bit pointers, start timeout 4). A hand-driven idle_st/u_rd_ptr stands in
// for the master bus FSM.
module tb_fifo_mst_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  wr_req, rd_req;
  logic [47:0] ep_rd_ptr_in;
  logic        idle_st, u_rd_ptr;
  logic [11:0] c_rd_ptr;
  logic        grant, m_rd_wr, busy, arb_err;
  logic [2:0]  ch_sel;
  logic [11:0] ep_rd_ptr, rd_ptr_val;
  logic [3:0]  rd_ptr_upd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_mst_arb #(.NUM_CH(4), .EPm_MSZ(11), .START_TMO(4)) dut (
    .clk(clk), .rstn(rstn), .wr_req(wr_req), .rd_req(rd_req),
    .ep_rd_ptr_in(ep_rd_ptr_in), .idle_st(idle_st), .u_rd_ptr(u_rd_ptr),
    .c_rd_ptr(c_rd_ptr), .grant(grant), .m_rd_wr(m_rd_wr), .ch_sel(ch_sel),
    .ep_rd_ptr(ep_rd_ptr), .rd_ptr_upd(rd_ptr_upd), .rd_ptr_val(rd_ptr_val),
    .busy(busy), .arb_err(arb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (grant === 1'b1) ok = 1'b1;
    end
  endtask

  // FSM leaves idle right after the grant, stays busy 6 cycles, then returns to idle.
  // The task ends with the arbiter back in ARB_IDLE.
  task automatic run_fsm();
    idle_st = 1'b0;
    repeat (6) tick();
    idle_st = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_req = '0; rd_req = '0; idle_st = 1'b1; u_rd_ptr = 1'b0;
    c_rd_ptr = '0;
    ep_rd_ptr_in = {12'h0DD, 12'h123, 12'h0BB, 12'h0AA};
    tick(); tick();
    checks++;
    if ({grant, busy, arb_err, m_rd_wr} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {grant, busy, arb_err, m_rd_wr});
    end
    checks++;
    if ({ch_sel, ep_rd_ptr, rd_ptr_upd, rd_ptr_val} !== '0) begin
      failures++;
      $display("FAIL reset_data: got ch=%0d ep=%h upd=%b val=%h expected all 0",
               ch_sel, ep_rd_ptr, rd_ptr_upd, rd_ptr_val);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wr_req = 4'b0100;
    tick();
    checks++;
    if (grant !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: grant=%b expected 1", grant);
    end
    checks++;
    if ({m_rd_wr, ch_sel, ep_rd_ptr, busy} !== {1'b0, 3'd2, 12'h123, 1'b1}) begin
      failures++;
      $display("FAIL single_sel: got rdwr=%b ch=%0d ep=%h busy=%b expected 0 2 123 1",
               m_rd_wr, ch_sel, ep_rd_ptr, busy);
    end
    wr_req = '0;
    tick();
    checks++;
    if ({grant, ch_sel, ep_rd_ptr} !== {1'b0, 3'd2, 12'h123}) begin
      failures++;
      $display("FAIL single_hold: got grant=%b ch=%0d ep=%h expected 0 2 123",
               grant, ch_sel, ep_rd_ptr);
    end
    run_fsm();
    checks++;
    if ({grant, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_done: got grant=%b busy=%b expected 0 0", grant, busy);
    end
  endtask

  task automatic test_ptr_commit();
    bit ok;
    wr_req = 4'b0010;
    wait_grant(5, ok);
    checks++;
    if (!ok || {m_rd_wr, ch_sel} !== {1'b0, 3'd1}) begin
      failures++;
      $display("FAIL commit_wr_grant: got ok=%b rdwr=%b ch=%0d expected 1 0 1", ok, m_rd_wr, ch_sel);
    end
    wr_req = '0;
    idle_st = 1'b0;
    tick();
    u_rd_ptr = 1'b1; c_rd_ptr = 12'h040;
    tick();
    checks++;
    if ({rd_ptr_upd, rd_ptr_val} !== {4'b0010, 12'h040}) begin
      failures++;
      $display("FAIL commit_wr: got upd=%b val=%h expected 0010 040", rd_ptr_upd, rd_ptr_val);
    end
    u_rd_ptr = 1'b0;
    tick();
    checks++;
    if (rd_ptr_upd !== 4'b0000) begin
      failures++;
      $display("FAIL commit_pulse: got upd=%b expected 0000", rd_ptr_upd);
    end
    idle_st = 1'b1;
    tick(); tick();

    rd_req = 4'b0010;
    wait_grant(5, ok);
    checks++;
    if (!ok || {m_rd_wr, ch_sel} !== {1'b1, 3'd1}) begin
      failures++;
      $display("FAIL commit_rd_grant: got ok=%b rdwr=%b ch=%0d expected 1 1 1", ok, m_rd_wr, ch_sel);
    end
    rd_req = '0;
    idle_st = 1'b0;
    tick();
    u_rd_ptr = 1'b1; c_rd_ptr = 12'h055;
    tick();
    checks++;
    if (rd_ptr_upd !== 4'b0000) begin
      failures++;
      $display("FAIL commit_rd_ignored: got upd=%b expected 0000", rd_ptr_upd);
    end
    u_rd_ptr = 1'b0;
    idle_st = 1'b1;
    tick(); tick();

    u_rd_ptr = 1'b1;
    tick();
    checks++;
    if (rd_ptr_upd !== 4'b0000) begin
      failures++;
      $display("FAIL commit_idle_ignored: got upd=%b expected 0000", rd_ptr_upd);
    end
    u_rd_ptr = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    wr_req = 4'b0001;
    wait_grant(5, ok);
    checks++;
    if (!ok || ch_sel !== 3'd0) begin
      failures++;
      $display("FAIL tmo_grant: got ok=%b ch=%0d expected 1 0", ok, ch_sel);
    end
    repeat (4) tick();
    checks++;
    if ({arb_err, busy} !== 2'b01) begin
      failures++;
      $display("FAIL tmo_early: got err=%b busy=%b expected 0 1", arb_err, busy);
    end
    tick();
    checks++;
    if ({arb_err, busy} !== 2'b10) begin
      failures++;
      $display("FAIL tmo_err: got err=%b busy=%b expected 1 0", arb_err, busy);
    end
    tick();
    checks++;
    if ({grant, m_rd_wr, ch_sel} !== {1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL tmo_regrant: got grant=%b rdwr=%b ch=%0d expected 1 0 0", grant, m_rd_wr, ch_sel);
    end
    wr_req = '0;
    run_fsm();
    checks++;
    if (arb_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky: got err=%b expected 1", arb_err);
    end
  endtask

  // rr sits at rd0 here: the default build picks rd0, write priority picks wr3.
  task automatic test_wr_prio();
    bit ok;
    logic [3:0] exp;
`ifdef FIFO_MST_ARB_WR_PRIO_EN
    exp = {1'b0, 3'd3};
`else
    exp = {1'b1, 3'd0};
`endif
    rd_req = 4'b0001; wr_req = 4'b1000;
    wait_grant(5, ok);
    checks++;
    if (!ok || {m_rd_wr, ch_sel} !== exp) begin
      failures++;
      $display("FAIL prio_sel: got ok=%b rdwr/ch=%b expected %b", ok, {m_rd_wr, ch_sel}, exp);
    end
    rd_req = '0; wr_req = '0;
    run_fsm();
  endtask

  task automatic test_reset_busy();
    bit ok;
    wr_req = 4'b0100;
    wait_grant(5, ok);
    wr_req = '0;
    idle_st = 1'b0;
    tick(); tick();
    u_rd_ptr = 1'b1; c_rd_ptr = 12'h077;
    tick();
    checks++;
    if (!ok || {busy, rd_ptr_upd} !== {1'b1, 4'b0100}) begin
      failures++;
      $display("FAIL rstbusy_pre: got ok=%b busy=%b upd=%b expected 1 1 0100", ok, busy, rd_ptr_upd);
    end
    wr_req = 4'b1111; rd_req = 4'b1111;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({grant, busy, arb_err, rd_ptr_upd, ch_sel} !== '0) begin
      failures++;
      $display("FAIL rstbusy_async: got grant=%b busy=%b err=%b upd=%b ch=%0d expected all 0",
               grant, busy, arb_err, rd_ptr_upd, ch_sel);
    end
    u_rd_ptr = 1'b0;
    idle_st = 1'b1;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_fairness();
    bit ok;
    int s;
    wr_req = 4'b1111; rd_req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      s = k % 8;
      wait_grant(30, ok);
      checks++;
      if (!ok || {m_rd_wr, ch_sel} !== {s[0], 3'(s >> 1)}) begin
        failures++;
        $display("FAIL fair_%0d: got ok=%b rdwr=%b ch=%0d expected rdwr=%0d ch=%0d",
                 k, ok, m_rd_wr, ch_sel, s % 2, s / 2);
      end
      run_fsm();
    end
    wr_req = '0; rd_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ptr_commit();
    test_timeout();
    test_wr_prio();
    test_reset_busy();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
